sampling_rate_ctrl: RTL and testbench

Parametrised sample-rate strobe generator for the DDS datapath. Produces a one-cycle Enable strobe every BASE^Mode clocks on Fg_CLK. Mode is stepped up or down by front-panel buttons, or loaded directly. Mode changes are deferred to the end of the current sample period so the strobe train never glitches, and Ready reports that no change is pending.

---
 rtl/sampling_pkg.sv | 39 +++
 rtl/btn_edge_sync.sv | 30 +++
 rtl/sampling_rate_ctrl.sv | 127 ++++++++++++
 tb/tb_sampling_rate_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sampling_pkg.sv
// Shared types and elaboration-time helpers for the sample-rate strobe generator.
package sampling_pkg;

  // Widest mode index the helpers handle; callers cast down to their MODE_W.
  localparam int MODE_IDX_W = 8;
  typedef logic [MODE_IDX_W-1:0] mode_idx_t;

  // BASE^m, evaluated at elaboration time only (feeds constant tables).
  function automatic longint unsigned period(input int base, input int m);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < m; i++) p = p * longint'(base);
    return p;
  endfunction

  // The longest period's terminal count must fit in the period counter.
  function automatic bit div_w_ok(input int base, input int num_modes, input int div_w);
    return (period(base, num_modes - 1) - 1) < (64'd1 << div_w);
  endfunction

  // Every mode index must be representable on the Mode port.
  function automatic bit mode_w_ok(input int num_modes, input int mode_w);
    return (num_modes >= 2) && (num_modes <= (1 << mode_w));
  endfunction

  // One up/down step inside 0..num_modes-1, either wrapping or saturating.
  function automatic mode_idx_t step_mode(input mode_idx_t m, input bit up,
                                          input int num_modes, input bit wrap);
    mode_idx_t max_m;
    max_m = mode_idx_t'(num_modes - 1);
    if (up) begin
      if (m >= max_m) return wrap ? '0 : max_m;
      return m + mode_idx_t'(1);
    end
    if (m == '0) return wrap ? max_m : '0;
    return m - mode_idx_t'(1);
  endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Two-flop synchroniser for a raw front-panel button plus a rising-edge pulse.
// The pulse is combinational off the synchronised level, so a request is
// registered by the consumer on the third clock edge after the button rises.
module btn_edge_sync (
  input  logic Fg_CLK,
  input  logic RESET,
  input  logic btn,
  output logic pulse
);

  logic meta;
  logic sync;
  logic sync_d;

  // Bring the asynchronous level into the clock domain and keep one cycle of history.
  always_ff @(posedge Fg_CLK or posedge RESET) begin
    if (RESET) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      meta   <= btn;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  assign pulse = sync & ~sync_d;

endmodule

// File: rtl/sampling_rate_ctrl.sv
// Sample-rate strobe generator: one-cycle Enable every BASE^Mode clocks.
// Mode requests (buttons or direct load) are held as a pending value and only
// applied on the last clock of the current period, so the strobe train never
// glitches. Ready = 1 means no change is pending; it drops on the edge a
// request is accepted and returns on the edge the pending mode is applied.
module sampling_rate_ctrl
  import sampling_pkg::*;
#(
  parameter int NUM_MODES    = 5,
  parameter int BASE         = 10,
  parameter int DIV_W        = 15,
  parameter int MODE_W       = 4,
  parameter int DEFAULT_MODE = 0,
  parameter bit WRAP         = 1'b1
) (
  input  logic              Fg_CLK,
  input  logic              RESET,
  input  logic              BtnUp,
  input  logic              BtnDn,
  input  logic              Mode_Load,
  input  logic [MODE_W-1:0] Mode_In,
  output logic              Enable,
  output logic              Ready,
  output logic [MODE_W-1:0] Mode
);

  if (!div_w_ok(BASE, NUM_MODES, DIV_W)) begin : g_bad_div_w
    $fatal(1, "sampling_rate_ctrl: DIV_W too small for BASE^(NUM_MODES-1)");
  end
  if (!mode_w_ok(NUM_MODES, MODE_W)) begin : g_bad_mode_w
    $fatal(1, "sampling_rate_ctrl: NUM_MODES must be 2..2^MODE_W");
  end
  if (DEFAULT_MODE < 0 || DEFAULT_MODE >= NUM_MODES) begin : g_bad_default
    $fatal(1, "sampling_rate_ctrl: DEFAULT_MODE out of range");
  end

  // Terminal count (P-1) per mode; entries beyond NUM_MODES are never selected.
  logic [DIV_W-1:0] last_cnt [2**MODE_W];
  for (genvar g = 0; g < 2**MODE_W; g++) begin : g_period
    if (g < NUM_MODES) begin : g_used
      assign last_cnt[g] = DIV_W'(period(BASE, g) - 1);
    end else begin : g_unused
      assign last_cnt[g] = '0;
    end
  end

  logic up_pulse;
  logic dn_pulse;

  btn_edge_sync u_up_sync (
    .Fg_CLK (Fg_CLK),
    .RESET  (RESET),
    .btn    (BtnUp),
    .pulse  (up_pulse)
  );

  btn_edge_sync u_dn_sync (
    .Fg_CLK (Fg_CLK),
    .RESET  (RESET),
    .btn    (BtnDn),
    .pulse  (dn_pulse)
  );

  logic [DIV_W-1:0]  cnt;
  logic              pend_valid;
  logic [MODE_W-1:0] pend_mode;

  logic              boundary;
  logic              apply;
  logic              load_ok;
  logic              req;
  logic              eff_pend;
  logic [MODE_W-1:0] eff_mode;
  logic [MODE_W-1:0] base_mode;
  logic [MODE_W-1:0] target;
  logic              nxt_valid;
  logic [MODE_W-1:0] nxt_mode;

  // Resolve this edge's apply and request into the next mode/pending pair.
  always_comb begin
    boundary  = (cnt == last_cnt[Mode]);
    apply     = boundary & pend_valid;
    eff_mode  = apply ? pend_mode : Mode;
    eff_pend  = pend_valid & ~apply;
    base_mode = eff_pend ? pend_mode : eff_mode;
    load_ok   = Mode_Load & ({1'b0, Mode_In} < (MODE_W+1)'(NUM_MODES));
    req       = 1'b0;
    target    = base_mode;
    if (load_ok) begin
      req    = 1'b1;
      target = Mode_In;
    end else if (up_pulse && !dn_pulse) begin
      req    = 1'b1;
      target = MODE_W'(step_mode(mode_idx_t'(base_mode), 1'b1, NUM_MODES, WRAP));
    end else if (dn_pulse && !up_pulse) begin
      req    = 1'b1;
      target = MODE_W'(step_mode(mode_idx_t'(base_mode), 1'b0, NUM_MODES, WRAP));
    end
    nxt_valid = eff_pend;
    nxt_mode  = pend_mode;
    // A request that lands on the active mode with nothing pending is a no-op.
    if (req && (eff_pend || (target != eff_mode))) begin
      nxt_valid = 1'b1;
      nxt_mode  = target;
    end
  end

  // Period counter, strobe, active mode and pending request registers.
  always_ff @(posedge Fg_CLK or posedge RESET) begin
    if (RESET) begin
      cnt        <= '0;
      Enable     <= 1'b0;
      Mode       <= MODE_W'(DEFAULT_MODE);
      pend_valid <= 1'b0;
      pend_mode  <= MODE_W'(DEFAULT_MODE);
      Ready      <= 1'b1;
    end else begin
      Enable     <= boundary;
      cnt        <= boundary ? '0 : cnt + DIV_W'(1);
      Mode       <= eff_mode;
      pend_valid <= nxt_valid;
      pend_mode  <= nxt_mode;
      Ready      <= ~nxt_valid;
    end
  end

endmodule

// File: tb/tb_sampling_rate_ctrl.sv
// Bench for sampling_rate_ctrl: one wrapping and one saturating instance
// share the stimulus; each is checked every cycle against its own model.
module tb_sampling_rate_ctrl;

  localparam int NUM_MODES = 5;
  localparam int BASE      = 10;
  localparam int MODE_W    = 4;

  // ---------------- clock / reset ----------------
  logic              Fg_CLK    = 1'b0;
  logic              RESET     = 1'b1;
  logic              BtnUp     = 1'b0;
  logic              BtnDn     = 1'b0;
  logic              Mode_Load = 1'b0;
  logic [MODE_W-1:0] Mode_In   = '0;

  logic              en_w, rdy_w;
  logic [MODE_W-1:0] mode_w;
  logic              en_s, rdy_s;
  logic [MODE_W-1:0] mode_s;

  int tests = 0;
  int fails = 0;

  always #5 Fg_CLK = ~Fg_CLK;

  sampling_rate_ctrl #(
    .NUM_MODES(NUM_MODES), .BASE(BASE), .DIV_W(15), .MODE_W(MODE_W),
    .DEFAULT_MODE(0), .WRAP(1'b1)
  ) dut_wrap (
    .Fg_CLK(Fg_CLK), .RESET(RESET), .BtnUp(BtnUp), .BtnDn(BtnDn),
    .Mode_Load(Mode_Load), .Mode_In(Mode_In),
    .Enable(en_w), .Ready(rdy_w), .Mode(mode_w)
  );

  sampling_rate_ctrl #(
    .NUM_MODES(NUM_MODES), .BASE(BASE), .DIV_W(15), .MODE_W(MODE_W),
    .DEFAULT_MODE(0), .WRAP(1'b0)
  ) dut_sat (
    .Fg_CLK(Fg_CLK), .RESET(RESET), .BtnUp(BtnUp), .BtnDn(BtnDn),
    .Mode_Load(Mode_Load), .Mode_In(Mode_In),
    .Enable(en_s), .Ready(rdy_s), .Mode(mode_s)
  );

  // ---------------- behavioural model ----------------
  typedef struct {
    int       mode;   // active mode
    int       pend;   // pending mode, -1 = none
    int       phase;  // edges elapsed in the current period
    bit       en;
    logic [2:0] uh;   // BtnUp samples of the previous three edges, [0] newest
    logic [2:0] dh;
  } mdl_t;

  function automatic int ipow(input int b, input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = r * b;
    return r;
  endfunction

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.mode = 0; r.pend = -1; r.phase = 0; r.en = 1'b0; r.uh = '0; r.dh = '0;
    return r;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t s, input bit wrap, input logic up,
                                    input logic dn, input logic ld, input int mi);
    mdl_t n = s;
    int   p = ipow(BASE, s.mode);
    bit   up_r = s.uh[1] & ~s.uh[2];
    bit   dn_r = s.dh[1] & ~s.dh[2];
    bit   req = 1'b0;
    int   tgt = 0;
    int   base;
    n.uh    = {s.uh[1:0], up};
    n.dh    = {s.dh[1:0], dn};
    n.phase = s.phase + 1;
    n.en    = (n.phase == p);
    if (n.en) begin
      n.phase = 0;
      if (s.pend >= 0) begin
        n.mode = s.pend;
        n.pend = -1;
      end
    end
    base = (n.pend >= 0) ? n.pend : n.mode;
    if (ld && mi < NUM_MODES) begin
      req = 1'b1; tgt = mi;
    end else if (up_r && !dn_r) begin
      req = 1'b1;
      tgt = wrap ? (base + 1) % NUM_MODES : ((base + 1 > NUM_MODES - 1) ? NUM_MODES - 1 : base + 1);
    end else if (dn_r && !up_r) begin
      req = 1'b1;
      tgt = wrap ? (base + NUM_MODES - 1) % NUM_MODES : ((base == 0) ? 0 : base - 1);
    end
    if (req && !(n.pend < 0 && tgt == n.mode)) n.pend = tgt;
    return n;
  endfunction

  function automatic logic [5:0] pack_exp(input mdl_t m);
    return {m.en, (m.pend < 0), 4'(m.mode)};
  endfunction

  mdl_t mw, ms;
  logic [5:0] exp_q_w[$];
  logic [5:0] exp_q_s[$];

  // Model advances on the same events as the DUTs and queues the expected outputs.
  always @(posedge Fg_CLK or posedge RESET) begin
    if (RESET) begin
      mw = mdl_reset();
      ms = mdl_reset();
      exp_q_w.delete();
      exp_q_s.delete();
    end else begin
      mw = mdl_step(mw, 1'b1, BtnUp, BtnDn, Mode_Load, int'(Mode_In));
      ms = mdl_step(ms, 1'b0, BtnUp, BtnDn, Mode_Load, int'(Mode_In));
    end
    exp_q_w.push_back(pack_exp(mw));
    exp_q_s.push_back(pack_exp(ms));
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare both instances against the model once per cycle, away from the active edge.
  always @(negedge Fg_CLK) begin
    if (exp_q_w.size() > 0) check("wrap_outputs", {26'd0, en_w, rdy_w, mode_w}, {26'd0, exp_q_w.pop_front()});
    if (exp_q_s.size() > 0) check("sat_outputs",  {26'd0, en_s, rdy_s, mode_s}, {26'd0, exp_q_s.pop_front()});
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge Fg_CLK);
  endtask

  task automatic press(input bit up, input bit dn);
    BtnUp = up; BtnDn = dn;
    tick(4);
    BtnUp = 1'b0; BtnDn = 1'b0;
    tick(4);
  endtask

  task automatic load(input int v);
    Mode_In = MODE_W'(v); Mode_Load = 1'b1;
    tick(1);
    Mode_Load = 1'b0;
  endtask

  task automatic wait_mode(input string nm, input int exp, input int budget);
    int n = 0;
    while (mode_w !== MODE_W'(exp) && n < budget) begin
      tick(1); n++;
    end
    check(nm, 32'(mode_w), exp);
  endtask

  task automatic measure(input string nm, input int exp, input int budget);
    int n = 0;
    while (en_w !== 1'b1 && n < budget) begin
      tick(1); n++;
    end
    n = 0;
    do begin
      tick(1); n++;
    end while (en_w !== 1'b1 && n < budget);
    check(nm, n, exp);
  endtask

  task automatic do_reset();
    #2 RESET = 1'b1;
    tick(2);
    RESET = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    tick(3);
    check("rst_enable", 32'(en_w), 0);
    check("rst_ready",  32'(rdy_w), 1);
    check("rst_mode",   32'(mode_w), 0);
    check("rst_mode_sat", 32'(mode_s), 0);
    RESET = 1'b0;
    tick(1);
    check("p1_first_edge", 32'(en_w), 1);
    tick(3);

    // Load mode 2 at P=1: pending for one cycle, then applied.
    load(2);
    check("load2_ready_low", 32'(rdy_w), 0);
    check("load2_mode_old",  32'(mode_w), 0);
    tick(1);
    check("load2_applied", 32'(mode_w), 2);
    check("load2_ready_hi", 32'(rdy_w), 1);
    measure("period_100", 100, 300);

    // Mode 3, BtnUp at cnt=200, applied at the 1000-clock boundary.
    load(3);
    wait_mode("mode3", 3, 300);
    tick(200);
    BtnUp = 1'b1;
    tick(2);
    check("up_latency_2", 32'(rdy_w), 1);
    tick(1);
    check("up_latency_3", 32'(rdy_w), 0);
    BtnUp = 1'b0;
    tick(796);
    check("mode3_hold", 32'(mode_w), 3);
    tick(1);
    check("mode4_applied", 32'(mode_w), 4);
    check("final_strobe", 32'(en_w), 1);
    measure("period_10000", 10000, 10500);

    // Up from the top mode: wrap instance goes to 0, saturating one stays at 4.
    press(1'b1, 1'b0);
    wait_mode("wrap_to_0", 0, 11000);
    check("sat_hold_4", 32'(mode_s), 4);
    check("sat_ready", 32'(rdy_s), 1);

    // Several requests inside one period collapse into a single apply.
    do_reset();
    load(2);
    tick(1);
    check("mode2_wrap", 32'(mode_w), 2);
    check("mode2_sat",  32'(mode_s), 2);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    check("multi_pending", 32'(rdy_w), 0);
    wait_mode("multi_apply", 3, 200);
    press(1'b1, 1'b1);
    check("both_ignored_rdy", 32'(rdy_w), 1);
    check("both_ignored_mode", 32'(mode_w), 3);

    // Out-of-range load ignored; load beats a same-cycle button edge.
    load(7);
    check("load_oob", 32'(rdy_w), 1);
    BtnUp = 1'b1;
    tick(2);
    load(1);
    check("load_vs_btn_pending", 32'(rdy_w), 0);
    BtnUp = 1'b0;
    wait_mode("load_wins", 1, 1100);

    // Reset in the middle of a period with a request pending.
    load(3);
    wait_mode("mode3_again", 3, 50);
    press(1'b1, 1'b0);
    tick(492);
    check("pend_before_rst", 32'(rdy_w), 0);
    #2 RESET = 1'b1;
    #1;
    check("midrst_mode",   32'(mode_w), 0);
    check("midrst_enable", 32'(en_w), 0);
    check("midrst_ready",  32'(rdy_w), 1);
    check("midrst_mode_sat", 32'(mode_s), 0);
    tick(2);
    RESET = 1'b0;
    tick(1);
    check("post_rst_enable", 32'(en_w), 1);

    // Down from mode 0: wrap to 4, saturating instance stays idle.
    press(1'b0, 1'b1);
    check("dn_wrap_4", 32'(mode_w), 4);
    check("dn_sat_0", 32'(mode_s), 0);
    check("dn_sat_ready", 32'(rdy_s), 1);
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
